ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipeline, sitting directly upstream of the MEM stage. It latches decoded operands and computes the ALU result or the effective memory address. Single-cycle ALU ops retire in one cycle; MUL/DIV use an iterative 32-step unit that stalls the front end through a ready/valid handshake. Registered outputs drive MEM's `IR_in`, `PC_in`, `Z_in` and `Addr` directly.

## Interface
- `WIDTH`, 32 (global from params.v): datapath width; PC is `WIDTH-2` bits.
- `ITER`, 32: MUL/DIV iteration count; equals `WIDTH`.

- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `flush` in 1: squash in-flight and incoming work.
- `IR_in` in WIDTH: instruction; opcode is `IR_in[31:26]`, imm16 is `[15:0]`.
- `PC_in` in WIDTH-2: instruction PC.
- `A_in`, `B_in` in WIDTH each: register operands rs and rt.
- `out_valid` out 1: output registers hold a real instruction.
- `IR_out` out WIDTH: to MEM `IR_in`; 0 (NOP) on bubble.
- `PC_out` out WIDTH-2: to MEM `PC_in`.
- `Z_out` out WIDTH: ALU result, or store data for SW/SH/SD.
- `Addr_out` out WIDTH: effective address for loads and stores, else 0.

## Operation
- Accept happens when `in_valid && in_ready && !flush`.
- Opcode macros come from ISA.v.
- Single-cycle ops:
  - ADD/SUB/AND/OR/SLT: `Z = A op B`, mod 2^32; SLT is signed, result 0 or 1.
  - ADDI: `Z = A + sext(imm16)`.
  - LW/LH/LD: `Addr = A + sext(imm16)`; `Z = 0`.
  - SW/SH/SD: `Addr = A + sext(imm16)`; `Z = B`.
  - Unknown opcode: `IR`/`PC` pass through; `Z = 0`, `Addr = 0`; `out_valid = 1`.
- FSM states IDLE, BUSY, DONE:
  - IDLE: accept of MUL/DIV goes to BUSY, latching A, B, IR, PC, and clearing count and accumulators. Any other accept loads the output registers directly and stays IDLE.
  - BUSY: one iteration per cycle, count 0..31. When count reaches 31, go to DONE.
  - DONE: load the output registers and go to IDLE. No accept is possible in DONE.
- MUL: unsigned shift-add; `Z` = low 32 bits of the product.
- DIV: unsigned restoring divide; `Z` = quotient.
  - Divide by zero: `Z = 32'hFFFFFFFF`; must still take the full 32 iterations.
- `in_ready` is 1 only in IDLE and not under `rst`.
- Bubble: any cycle without a load writes `IR_out = 0`, `Z_out = 0`, `Addr_out = 0`, `out_valid = 0`. `PC_out` holds its value.
- `flush`: in any state, the next edge goes to IDLE and writes a bubble. Flush takes priority over a simultaneous accept, which is dropped.
- `rst` mid-BUSY: aborts the operation; no output is produced.

## Timing
- Reset values: `out_valid = 0`, `IR_out = 0`, `PC_out = 0`, `Z_out = 0`, `Addr_out = 0`, state IDLE, count 0. `in_ready = 1` from the first cycle after `rst` deasserts.
- Single-cycle latency: accepted at edge N, outputs valid after edge N. Back-to-back accepts are allowed every cycle.
- MUL/DIV latency: accepted at edge N; BUSY on edges N+1..N+32; DONE loads outputs at edge N+33.
  - `in_ready = 0` for cycles N+1..N+33.
  - Next accept is possible at edge N+34.
  - `out_valid` is a bubble (0) during edges N+1..N+32.
- `out_valid` is high for exactly one cycle per instruction. There is no downstream backpressure, because MEM is combinational.

## Configuration
- `EX_MULDIV_EN` defined: MUL/DIV unit, BUSY/DONE states and `ITER` counter are compiled in, as described above.
- `EX_MULDIV_EN` undefined: no iterative hardware is built.
  - MUL/DIV are treated as unknown opcodes: single cycle, `Z = 0`.
  - `in_ready` is 1 whenever `rst = 0`.
  - The FSM reduces to IDLE only.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid = 1` -> all outputs 0, `in_ready = 0` during reset, 1 on the first cycle after.
- ADD then SW back-to-back:
  - ADD with A=7, B=5 -> `Z_out = 12` one cycle later.
  - Next cycle, SW with A=0x100, imm=0xFFFC, B=0xDEAD -> `Addr_out = 0xFC`, `Z_out = 0xDEAD`.
  - `out_valid` high both cycles.
- MUL with A=0x10000, B=0x10001 -> `in_ready` low 33 cycles, 32 bubbles, then `Z_out = 0x00010000` (low word), `out_valid` for 1 cycle.
- DIV cases:
  - A=100, B=7 -> `Z_out = 14` after 33 cycles.
  - A=5, B=0 -> `Z_out = 0xFFFFFFFF` with identical latency.
- `flush` at BUSY iteration 10 with `in_valid` also high -> bubble next cycle, IDLE, `in_ready = 1`. The flushed input is never output.
- `EX_MULDIV_EN` undefined: MUL with A=3, B=4 -> single cycle, `Z_out = 0`, `out_valid = 1`, `in_ready` never drops.

Source files
------------

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU / address generation plus optional iterative MUL/DIV
//
// Optional feature macro: EX_MULDIV_EN (defined -> iterative 32-step MUL/DIV unit with IDLE/BUSY/DONE FSM;
// undefined -> MUL/DIV decode as unknown opcodes and the stage is purely single-cycle).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready handshake with decode
//   flush               squash in-flight and incoming work
//   IR_in, PC_in        instruction word and its PC
//   A_in, B_in          rs / rt operands
//   out_valid           output registers hold a real instruction
//   IR_out, PC_out      to MEM IR_in / PC_in (IR_out is 0 on a bubble, PC_out holds)
//   Z_out               ALU result, store data, or MUL/DIV result
//   Addr_out            effective address for loads/stores, else 0
module ex_stage #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [WIDTH-1:0]   IR_in,
    input  logic [WIDTH-3:0]   PC_in,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic               out_valid,
    output logic [WIDTH-1:0]   IR_out,
    output logic [WIDTH-3:0]   PC_out,
    output logic [WIDTH-1:0]   Z_out,
    output logic [WIDTH-1:0]   Addr_out
);

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_SLT  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd16;
    localparam logic [5:0] OP_LH   = 6'd17;
    localparam logic [5:0] OP_LD   = 6'd18;
    localparam logic [5:0] OP_SW   = 6'd20;
    localparam logic [5:0] OP_SH   = 6'd21;
    localparam logic [5:0] OP_SD   = 6'd22;
    localparam logic [5:0] OP_MUL  = 6'd24;
    localparam logic [5:0] OP_DIV  = 6'd25;

    logic [5:0]       op;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] eff_addr;
    logic [WIDTH-1:0] sc_z;
    logic [WIDTH-1:0] sc_addr;
    logic             is_muldiv;
    logic             accept;

    // Single-cycle result for whatever decode is presenting this cycle.
    always_comb begin
        op        = IR_in[31:26];
        imm_sext  = {{(WIDTH-16){IR_in[15]}}, IR_in[15:0]};
        eff_addr  = A_in + imm_sext;
        sc_z      = '0;
        sc_addr   = '0;
        is_muldiv = 1'b0;
        case (op)
            OP_ADD:  sc_z = A_in + B_in;
            OP_SUB:  sc_z = A_in - B_in;
            OP_AND:  sc_z = A_in & B_in;
            OP_OR:   sc_z = A_in | B_in;
            OP_SLT:  sc_z = {{(WIDTH-1){1'b0}}, ($signed(A_in) < $signed(B_in))};
            OP_ADDI: sc_z = eff_addr;
            OP_LW, OP_LH, OP_LD: sc_addr = eff_addr;
            OP_SW, OP_SH, OP_SD: begin
                sc_addr = eff_addr;
                sc_z    = B_in;
            end
`ifdef EX_MULDIV_EN
            OP_MUL, OP_DIV: is_muldiv = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready && !flush;

`ifdef EX_MULDIV_EN
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             md_div;
    logic [WIDTH-1:0] md_ir;
    logic [WIDTH-3:0] md_pc;
    // MUL: acc = partial product, a_r = shifted multiplicand, b_r = shifted multiplier.
    // DIV: acc = partial remainder, a_r = dividend shifting out / quotient shifting in, b_r = divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;

    // With a zero divisor every trial subtraction succeeds, so the quotient fills with ones.
    always_comb begin
        rem_sh  = {acc, a_r[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, b_r});
        rem_sub = rem_sh - {1'b0, b_r};
    end

    assign in_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            md_div    <= 1'b0;
            md_ir     <= '0;
            md_pc     <= '0;
            acc       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            out_valid <= 1'b0;
            IR_out    <= '0;
            PC_out    <= '0;
            Z_out     <= '0;
            Addr_out  <= '0;
        end else begin
            out_valid <= 1'b0;
            IR_out    <= '0;
            Z_out     <= '0;
            Addr_out  <= '0;
            if (flush) begin
                state <= S_IDLE;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept && is_muldiv) begin
                            state  <= S_BUSY;
                            count  <= '0;
                            md_div <= (op == OP_DIV);
                            md_ir  <= IR_in;
                            md_pc  <= PC_in;
                            acc    <= '0;
                            a_r    <= A_in;
                            b_r    <= B_in;
                        end else if (accept) begin
                            out_valid <= 1'b1;
                            IR_out    <= IR_in;
                            PC_out    <= PC_in;
                            Z_out     <= sc_z;
                            Addr_out  <= sc_addr;
                        end
                    end
                    S_BUSY: begin
                        if (md_div) begin
                            acc <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                            a_r <= {a_r[WIDTH-2:0], rem_ge};
                        end else begin
                            if (b_r[0]) acc <= acc + a_r;
                            a_r <= a_r << 1;
                            b_r <= b_r >> 1;
                        end
                        count <= count + 1'b1;
                        if (count == LAST) state <= S_DONE;
                    end
                    S_DONE: begin
                        out_valid <= 1'b1;
                        IR_out    <= md_ir;
                        PC_out    <= md_pc;
                        Z_out     <= md_div ? a_r : acc;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
`else
    assign in_ready = !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            IR_out    <= '0;
            PC_out    <= '0;
            Z_out     <= '0;
            Addr_out  <= '0;
        end else begin
            out_valid <= 1'b0;
            IR_out    <= '0;
            Z_out     <= '0;
            Addr_out  <= '0;
            if (accept) begin
                out_valid <= 1'b1;
                IR_out    <= IR_in;
                PC_out    <= PC_in;
                Z_out     <= sc_z;
                Addr_out  <= sc_addr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_SLT = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd20;
    localparam logic [5:0] OP_MUL = 6'd24;
    localparam logic [5:0] OP_DIV = 6'd25;
    localparam logic [5:0] OP_BAD = 6'd63;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] IR_in;
    logic [29:0] PC_in;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        out_valid;
    logic [31:0] IR_out;
    logic [29:0] PC_out;
    logic [31:0] Z_out;
    logic [31:0] Addr_out;

    int errors = 0;
    int checks = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .IR_in(IR_in), .PC_in(PC_in), .A_in(A_in), .B_in(B_in),
        .out_valid(out_valid), .IR_out(IR_out), .PC_out(PC_out),
        .Z_out(Z_out), .Addr_out(Addr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'b0, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [15:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [29:0] pc);
        in_valid = 1'b1;
        IR_in    = mk(op, imm);
        A_in     = a;
        B_in     = b;
        PC_in    = pc;
    endtask

`ifdef EX_MULDIV_EN
    task automatic run_muldiv(input string tag, input logic [5:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int ready_low;
        int bubbles;
        ready_low = 0;
        bubbles   = 0;
        drive(op, 16'h0, a, b, 30'h123);
        check({tag, "_ready_before"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        if (!in_ready) ready_low++;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (!in_ready) ready_low++;
            if (!out_valid && IR_out == 32'h0) bubbles++;
        end
        tick();
        check({tag, "_ready_low_cycles"}, ready_low, 33);
        check({tag, "_bubbles"}, bubbles, 32);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_z"}, Z_out, exp);
        check({tag, "_ir"}, IR_out, mk(op, 16'h0));
        check({tag, "_addr"}, Addr_out, 32'h0);
        check({tag, "_ready_after"}, {31'b0, in_ready}, 32'd1);
        tick();
        check({tag, "_valid_one_cycle"}, {31'b0, out_valid}, 32'd0);
    endtask
`endif

    initial begin
        int seen;
        rst      = 1'b1;
        flush    = 1'b0;
        drive(OP_ADD, 16'h0, 32'd1, 32'd1, 30'h55);

        // Reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ready", {31'b0, in_ready}, 32'd0);
            check("rst_valid", {31'b0, out_valid}, 32'd0);
            check("rst_z", Z_out | IR_out | Addr_out | {2'b0, PC_out}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // ADD then SW back to back
        drive(OP_ADD, 16'h0, 32'd7, 32'd5, 30'h10);
        tick();
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_z", Z_out, 32'd12);
        check("add_addr", Addr_out, 32'd0);
        check("add_pc", {2'b0, PC_out}, 32'h10);
        drive(OP_SW, 16'hFFFC, 32'h100, 32'hDEAD, 30'h11);
        tick();
        check("sw_valid", {31'b0, out_valid}, 32'd1);
        check("sw_addr", Addr_out, 32'hFC);
        check("sw_z", Z_out, 32'hDEAD);
        check("sw_ir", IR_out, mk(OP_SW, 16'hFFFC));

        // Other single-cycle ops
        drive(OP_SUB, 16'h0, 32'd3, 32'd5, 30'h12);
        tick();
        check("sub_wrap", Z_out, 32'hFFFF_FFFE);
        drive(OP_SLT, 16'h0, 32'hFFFF_FFFF, 32'd1, 30'h13);
        tick();
        check("slt_signed", Z_out, 32'd1);
        drive(OP_LW, 16'h0008, 32'h200, 32'h77, 30'h14);
        tick();
        check("lw_addr", Addr_out, 32'h208);
        check("lw_z", Z_out, 32'd0);
        drive(OP_BAD, 16'h1234, 32'h9, 32'h9, 30'h15);
        tick();
        check("bad_valid", {31'b0, out_valid}, 32'd1);
        check("bad_ir", IR_out, mk(OP_BAD, 16'h1234));
        check("bad_z", Z_out | Addr_out, 32'd0);

        // Bubble: PC holds, everything else cleared
        in_valid = 1'b0;
        tick();
        check("bubble_valid", {31'b0, out_valid}, 32'd0);
        check("bubble_ir", IR_out, 32'd0);
        check("bubble_pc", {2'b0, PC_out}, 32'h15);

        // Flush beats a simultaneous accept in IDLE
        drive(OP_ADD, 16'h0, 32'd1, 32'd2, 30'h20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_valid", {31'b0, out_valid}, 32'd0);
        check("flush_idle_z", Z_out, 32'd0);

`ifdef EX_MULDIV_EN
        run_muldiv("mul", OP_MUL, 32'h10000, 32'h10001, 32'h0001_0000);
        run_muldiv("div", OP_DIV, 32'd100, 32'd7, 32'd14);
        run_muldiv("div0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);

        // Flush at BUSY iteration 10 with an incoming ADD
        drive(OP_MUL, 16'h0, 32'd6, 32'd7, 30'h30);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        drive(OP_ADD, 16'h0, 32'd1, 32'd1, 30'h31);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_busy_valid", {31'b0, out_valid}, 32'd0);
        check("flush_busy_ir", IR_out, 32'd0);
        check("flush_busy_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush_no_output", seen, 0);

        // Reset mid-BUSY aborts the operation
        drive(OP_DIV, 16'h0, 32'd50, 32'd5, 30'h40);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_busy_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_busy_no_output", seen, 0);
`else
        // Without the iterative unit MUL is an unknown opcode
        drive(OP_MUL, 16'h0, 32'd3, 32'd4, 30'h30);
        check("mul_ready_before", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("mul_valid", {31'b0, out_valid}, 32'd1);
        check("mul_z", Z_out, 32'd0);
        check("mul_ir", IR_out, mk(OP_MUL, 16'h0));
        check("mul_ready_after", {31'b0, in_ready}, 32'd1);
        tick();
        check("mul_valid_one_cycle", {31'b0, out_valid}, 32'd0);
`endif

        // Stage still works afterwards
        drive(OP_ADD, 16'h0, 32'hFFFF_FFFF, 32'd2, 30'h50);
        tick();
        in_valid = 1'b0;
        check("final_add_valid", {31'b0, out_valid}, 32'd1);
        check("final_add_z", Z_out, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
